// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the handshaked pipeline stage register.
// Control bit positions follow the ID/EX control vector layout.
// No logic: types and constants only.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int CTRL_W_DEF = 9;
    localparam int DATA_W_DEF = 136;

    localparam int CTRL_WB_EN        = 8;
    localparam int CTRL_MEM_R_EN     = 7;
    localparam int CTRL_MEM_W_EN     = 6;
    localparam int CTRL_B            = 5;
    localparam int CTRL_S            = 4;
    localparam int CTRL_EXE_CMD_MSB  = 3;
    localparam int CTRL_EXE_CMD_LSB  = 0;

endpackage

// File: rtl/pipe_stage_perf_cnt.sv
// Saturating 32-bit event counter with enable and synchronous load.
// Latency: count visible the cycle after the enabled edge.
// Backpressure: none; load takes priority over counting.
module pipe_stage_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 32'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage with 2-entry skid buffer and flush; PIPE_STAGE_PERF_EN adds counters.
// Latency: 1 cycle in_fire -> out_valid; 1 entry/cycle while out_ready=1.
// Backpressure: in_ready decoded from state flop only; skid absorbs one entry, never drops.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W            = CTRL_W_DEF,
    parameter int DATA_W            = DATA_W_DEF,
    parameter bit CLR_DATA_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`else
    output logic [DATA_W-1:0] out_data
`endif
);

    stage_state_t      state, state_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
    logic              in_fire, out_fire;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            main_ctrl <= main_ctrl_nxt;
            main_data <= main_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            skid_data <= skid_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        main_ctrl_nxt = main_ctrl;
        main_data_nxt = main_data;
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;
        if (flush) begin
            // Kill everything held and drop any input offered this cycle.
            state_nxt     = EMPTY;
            main_ctrl_nxt = '0;
            skid_ctrl_nxt = '0;
            if (CLR_DATA_ON_FLUSH) begin
                main_data_nxt = '0;
                skid_data_nxt = '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt     = ONE;
                        main_ctrl_nxt = in_ctrl;
                        main_data_nxt = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_nxt = in_ctrl;
                        main_data_nxt = in_data;
                    end else if (in_fire) begin
                        state_nxt     = TWO;
                        skid_ctrl_nxt = in_ctrl;
                        skid_data_nxt = in_data;
                    end else if (out_fire) begin
                        // Zeroed ctrl makes the empty stage a harmless bubble.
                        state_nxt     = EMPTY;
                        main_ctrl_nxt = '0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt     = ONE;
                        main_ctrl_nxt = skid_ctrl;
                        main_data_nxt = skid_data;
                        skid_ctrl_nxt = '0;
                    end
                end
                default: begin
                    state_nxt     = EMPTY;
                    main_ctrl_nxt = '0;
                    skid_ctrl_nxt = '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_perf_cnt u_stall_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (out_valid & ~out_ready),
        .load     (1'b0),
        .load_val (32'd0),
        .cnt      (stall_cnt)
    );

    pipe_stage_perf_cnt u_bubble_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (~out_valid),
        .load     (1'b0),
        .load_val (32'd0),
        .cnt      (bubble_cnt)
    );

    pipe_stage_perf_cnt u_flush_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (flush),
        .load     (1'b0),
        .load_val (32'd0),
        .cnt      (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver queues expected entries, monitor pops on out_fire.
// A second instance with CLR_DATA_ON_FLUSH=0 shares the stimulus for the stale-data check.
module tb_pipe_stage_reg;
    localparam int CW = 9;
    localparam int DW = 136;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, nc_in_ready, nc_out_valid;
    logic [CW-1:0] out_ctrl, nc_out_ctrl;
    logic [DW-1:0] out_data, nc_out_data;

    int   errors = 0;
    int   checks = 0;
    ent_t exp_q[$];

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
    logic [31:0] nc_stall_cnt, nc_bubble_cnt, nc_flush_cnt;
    logic        sat_en = 1'b0, sat_load = 1'b0;
    logic [31:0] sat_val = 32'd0, sat_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA_ON_FLUSH(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
`ifdef PIPE_STAGE_PERF_EN
        .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`else
        .out_data(out_data)
`endif
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA_ON_FLUSH(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nc_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(nc_out_valid), .out_ready(out_ready), .out_ctrl(nc_out_ctrl),
`ifdef PIPE_STAGE_PERF_EN
        .out_data(nc_out_data),
        .stall_cnt(nc_stall_cnt), .bubble_cnt(nc_bubble_cnt), .flush_cnt(nc_flush_cnt)
`else
        .out_data(nc_out_data)
`endif
    );

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_perf_cnt u_sat (
        .clk(clk), .rst(rst), .en(sat_en), .load(sat_load), .load_val(sat_val), .cnt(sat_cnt)
    );
`endif

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CW-1:0] c, input logic [DW-1:0] d, input bit push);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        if (push) exp_q.push_back('{ctrl: c, data: d});
    endtask

    // Monitor: every accepted output must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            ent_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got ctrl 0x%0h data 0x%0h with nothing expected",
                         out_ctrl, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_ctrl !== e.ctrl || out_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_entry: got ctrl 0x%0h data 0x%0h expected ctrl 0x%0h data 0x%0h",
                             out_ctrl, out_data, e.ctrl, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_ctrl", DW'(out_ctrl), DW'(0));
        chk("rst_out_data", out_data, DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Streaming: one entry per cycle, visible right after its accepting edge.
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            chk("stream_in_ready", DW'(in_ready), DW'(1));
            drive(9'h1FF, DW'(k), 1'b1);
            cyc();
            chk("stream_out_valid", DW'(out_valid), DW'(1));
            chk("stream_out_data", out_data, DW'(k));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drain", DW'(out_valid), DW'(0));

        // Backpressure into the skid entry.
        drive(9'h0A5, DW'('h11), 1'b1);
        cyc();
        out_ready = 1'b0;
        chk("bp_in_ready_one", DW'(in_ready), DW'(1));
        drive(9'h15A, DW'('h22), 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("bp_in_ready_two", DW'(in_ready), DW'(0));
        chk("bp_hold_a", out_data, DW'('h11));
        cyc();
        chk("bp_hold_a2", out_data, DW'('h11));
        chk("bp_hold_ctrl", DW'(out_ctrl), DW'('h0A5));
        out_ready = 1'b1;
        cyc();
        chk("bp_b_next", out_data, DW'('h22));
        chk("bp_b_ctrl", DW'(out_ctrl), DW'('h15A));
        cyc();
        chk("bp_empty", DW'(out_valid), DW'(0));
        out_ready = 1'b0;

        // Flush while full, with an input offered.
        drive(9'h1FF, DW'('h44), 1'b1);
        cyc();
        drive(9'h1FF, DW'('h55), 1'b1);
        cyc();
        drive(9'h1FF, DW'('h33), 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("fl_out_valid", DW'(out_valid), DW'(0));
        chk("fl_out_ctrl", DW'(out_ctrl), DW'(0));
        chk("fl_out_data", out_data, DW'(0));
        chk("fl_in_ready", DW'(in_ready), DW'(1));
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("fl_no_c", DW'(out_valid), DW'(0));
        out_ready = 1'b0;

        // Stale data kept on the CLR_DATA_ON_FLUSH=0 instance; input accepted-looking but dropped.
        drive(9'h1FF, DW'('hABC), 1'b1);
        cyc();
        drive(9'h1FF, DW'('h77), 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("nc_out_data", nc_out_data, DW'('hABC));
        chk("nc_out_ctrl", DW'(nc_out_ctrl), DW'(0));
        chk("nc_out_valid", DW'(nc_out_valid), DW'(0));
        chk("clr_out_data", out_data, DW'(0));
        cyc();
        chk("fl_drop_input", DW'(out_valid), DW'(0));

        // Asynchronous reset while full.
        drive(9'h1FF, DW'('h5A), 1'b1);
        cyc();
        drive(9'h0FF, DW'('hA5), 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("ar_two", DW'(in_ready), DW'(0));
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("ar_out_valid", DW'(out_valid), DW'(0));
        chk("ar_out_ctrl", DW'(out_ctrl), DW'(0));
        chk("ar_out_data", out_data, DW'(0));
        chk("ar_nc_out_data", nc_out_data, DW'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_rel_in_ready", DW'(in_ready), DW'(1));
        chk("ar_rel_out_valid", DW'(out_valid), DW'(0));

        // Known sequence from reset release: 4 bubbles, 5 stalls, 2 flushes, 2 more bubbles.
        cyc();
        cyc();
        cyc();
        drive(9'h1FF, DW'('h99), 1'b1);
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        cyc();
        flush = 1'b0;
        cyc();
        out_ready = 1'b0;
        chk("perf_seq_empty", DW'(out_valid), DW'(0));
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", DW'(stall_cnt), DW'(5));
        chk("bubble_cnt", DW'(bubble_cnt), DW'(6));
        chk("flush_cnt", DW'(flush_cnt), DW'(2));
        sat_load = 1'b1;
        sat_val = 32'hFFFF_FFFD;
        cyc();
        sat_load = 1'b0;
        sat_en = 1'b1;
        cyc();
        chk("sat_step", DW'(sat_cnt), DW'(32'hFFFF_FFFE));
        repeat (3) cyc();
        chk("sat_hold", DW'(sat_cnt), DW'(32'hFFFF_FFFF));
        sat_en = 1'b0;
`endif

        cyc();
        chk("sb_drained", DW'(exp_q.size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
